// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv path: divider state encoding and
// the most-negative-value helper used for signed overflow detection.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    // Widest operand the helper below can describe.
    localparam int MAX_W = 64;

    // Two's-complement minimum for a w-bit word: a one followed by w-1 zeros.
    function automatic logic [MAX_W-1:0] min_neg(input int w);
        return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    endfunction

endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement negate, used both to take operand
// magnitudes and to restore result signs.
module twos_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             en,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Invert-and-increment when enabled, pass through otherwise.
    assign result = en ? (~value + ONE) : value;

endmodule

// File: rtl/signed_div_seq.sv
// Multicycle restoring divider: one quotient bit per cycle on operand
// magnitudes, followed by a sign fix-up cycle and a one-cycle ready pulse.
// Divide-by-zero and signed overflow are resolved immediately at start.
module signed_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             busy,
    output logic             exception
);

    import multdiv_pkg::*;

    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(min_neg(WIDTH));

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] div_b;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_q;
    logic             q_neg;
    logic             r_neg;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             b_zero;
    logic             ovf;
    logic             exc_case;
    logic             load;
    logic             ready_nxt;
    logic             busy_nxt;

    twos_negate #(.WIDTH(WIDTH)) u_neg_a (
        .value  (OPA),
        .en     (signed_mode & OPA[WIDTH-1]),
        .result (abs_a)
    );

    twos_negate #(.WIDTH(WIDTH)) u_neg_b (
        .value  (OPB),
        .en     (signed_mode & OPB[WIDTH-1]),
        .result (abs_b)
    );

    twos_negate #(.WIDTH(WIDTH)) u_fix_q (
        .value  (quo_q),
        .en     (q_neg),
        .result (fix_q)
    );

    twos_negate #(.WIDTH(WIDTH)) u_fix_r (
        .value  (rem_r),
        .en     (r_neg),
        .result (fix_r)
    );

    assign b_zero   = (OPB == '0);
    assign ovf      = signed_mode && (OPA == MIN_NEG) && (OPB == '1);
    assign exc_case = b_zero | ovf;
    assign load     = (state == IDLE) && start;

    // The partial remainder gains one extra bit so the subtract borrow
    // (rem_diff MSB) directly signals "shifted remainder < divisor".
    assign rem_shift = {rem_r, quo_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, div_b};

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and decode of the registered handshake outputs.
    always_comb begin
        state_nxt = state;
        ready_nxt = 1'b0;
        busy_nxt  = 1'b1;
        case (state)
            IDLE: begin
                busy_nxt = start;
                if (start) state_nxt = exc_case ? DONE : RUN;
            end
            RUN: begin
                if (cnt == '0) state_nxt = FIXUP;
            end
            FIXUP: begin
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake outputs: busy stays high through the ready cycle and only
    // drops if no new start arrives while ready is up.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready <= 1'b0;
            busy  <= 1'b0;
        end else begin
            ready <= ready_nxt;
            busy  <= busy_nxt;
        end
    end

    // Operand capture on start, then one restoring shift-subtract per RUN cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            div_b <= '0;
            rem_r <= '0;
            quo_q <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_b <= abs_b;
                        quo_q <= abs_a;
                        rem_r <= '0;
                        cnt   <= CNT_W'(WIDTH - 1);
                        q_neg <= signed_mode & (OPA[WIDTH-1] ^ OPB[WIDTH-1]);
                        r_neg <= signed_mode & OPA[WIDTH-1];
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (!rem_diff[WIDTH]) begin
                        rem_r <= rem_diff[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r <= rem_shift[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: exception cases are written at start, normal
    // results in the fix-up cycle; both hold until the next operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            quotient  <= '0;
            remainder <= '0;
            exception <= 1'b0;
        end else if (load) begin
            exception <= exc_case;
            if (b_zero) begin
                quotient  <= '0;
                remainder <= '0;
            end else if (ovf) begin
                quotient  <= MIN_NEG;
                remainder <= '0;
            end
        end else if (state == FIXUP) begin
            quotient  <= fix_q;
            remainder <= fix_r;
        end
    end

endmodule

// File: tb/tb_signed_div_seq.sv
// Self-checking bench for signed_div_seq: a 32-bit and an 8-bit instance,
// expected results queued at issue time and compared when ready appears.
module tb_signed_div_seq;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sm    = 1'b0;
    logic [31:0] opa   = '0;
    logic [31:0] opb   = '0;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        rdy;
    logic        bsy;
    logic        exc;

    logic        start8 = 1'b0;
    logic        sm8    = 1'b0;
    logic [7:0]  opa8   = '0;
    logic [7:0]  opb8   = '0;
    logic [7:0]  quo8;
    logic [7:0]  rem8;
    logic        rdy8;
    logic        bsy8;
    logic        exc8;

    int   passed = 0;
    int   total  = 0;
    exp_t sbq[$];

    always #5 clock = ~clock;

    signed_div_seq #(.WIDTH(32)) dut32 (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .signed_mode (sm),
        .OPA         (opa),
        .OPB         (opb),
        .quotient    (quo),
        .remainder   (rem),
        .ready       (rdy),
        .busy        (bsy),
        .exception   (exc)
    );

    signed_div_seq #(.WIDTH(8)) dut8 (
        .clock       (clock),
        .reset       (reset),
        .start       (start8),
        .signed_mode (sm8),
        .OPA         (opa8),
        .OPB         (opb8),
        .quotient    (quo8),
        .remainder   (rem8),
        .ready       (rdy8),
        .busy        (bsy8),
        .exception   (exc8)
    );

    function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t m;
        logic signed [31:0] sa;
        logic signed [31:0] sd;
        sa = a;
        sd = b;
        m  = '0;
        if (b == 32'd0) begin
            m.e = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m.q = 32'h8000_0000;
            m.e = 1'b1;
        end else if (s) begin
            m.q = sa / sd;
            m.r = sa % sd;
        end else begin
            m.q = a / b;
            m.r = a % b;
        end
        return m;
    endfunction

    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        exp_t m;
        logic signed [7:0] sa;
        logic signed [7:0] sd;
        sa = a;
        sd = b;
        m  = '0;
        if (b == 8'd0) begin
            m.e = 1'b1;
        end else if (s && a == 8'h80 && b == 8'hFF) begin
            m.q = {24'd0, 8'h80};
            m.e = 1'b1;
        end else if (s) begin
            m.q = {24'd0, 8'(sa / sd)};
            m.r = {24'd0, 8'(sa % sd)};
        end else begin
            m.q = {24'd0, a / b};
            m.r = {24'd0, a % b};
        end
        return m;
    endfunction

    // Issue one 32-bit operation and wait (bounded) for its ready pulse.
    // lat counts clock edges after the edge that samples start.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output exp_t got, output int lat, output bit ok, output bit gap);
        sbq.push_back(model32(a, b, s));
        opa   = a;
        opb   = b;
        sm    = s;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat = 0;
        ok  = 1'b0;
        gap = 1'b0;
        got = '0;
        while (!ok && lat < 100) begin
            if (!bsy) gap = 1'b1;
            if (rdy) begin
                ok  = 1'b1;
                got = {quo, rem, exc};
            end else begin
                @(posedge clock);
                #1;
                lat++;
            end
        end
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                          output exp_t got, output int lat, output bit ok, output bit gap);
        sbq.push_back(model8(a, b, s));
        opa8   = a;
        opb8   = b;
        sm8    = s;
        start8 = 1'b1;
        @(posedge clock);
        #1;
        start8 = 1'b0;
        lat = 0;
        ok  = 1'b0;
        gap = 1'b0;
        got = '0;
        while (!ok && lat < 100) begin
            if (!bsy8) gap = 1'b1;
            if (rdy8) begin
                ok  = 1'b1;
                got = {24'd0, quo8, 24'd0, rem8, exc8};
            end else begin
                @(posedge clock);
                #1;
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        total++; if (quo !== 32'd0) $display("FAIL reset quotient32: got %h want 0", quo); else passed++;
        total++; if (rem !== 32'd0) $display("FAIL reset remainder32: got %h want 0", rem); else passed++;
        total++; if (rdy !== 1'b0) $display("FAIL reset ready32: got %b want 0", rdy); else passed++;
        total++; if (bsy !== 1'b0) $display("FAIL reset busy32: got %b want 0", bsy); else passed++;
        total++; if (exc !== 1'b0) $display("FAIL reset exception32: got %b want 0", exc); else passed++;
        total++; if (quo8 !== 8'd0) $display("FAIL reset quotient8: got %h want 0", quo8); else passed++;
        total++; if (rem8 !== 8'd0) $display("FAIL reset remainder8: got %h want 0", rem8); else passed++;
        total++; if ({rdy8, bsy8, exc8} !== 3'b000) $display("FAIL reset ctrl8: got %b want 000", {rdy8, bsy8, exc8}); else passed++;
        reset = 1'b0;
        @(posedge clock);
        #1;
        total++; if ({rdy, bsy} !== 2'b00) $display("FAIL idle ctrl32: got %b want 00", {rdy, bsy}); else passed++;
    endtask

    task automatic test_arith();
        logic [31:0] ta [11];
        logic [31:0] tb [11];
        logic        ts [11];
        exp_t got;
        exp_t want;
        int   lat;
        bit   ok;
        bit   gap;
        ta[0] = 32'd7;          tb[0] = 32'd2;          ts[0] = 1'b1;
        ta[1] = 32'hFFFF_FFF9;  tb[1] = 32'd2;          ts[1] = 1'b1;
        ta[2] = 32'd7;          tb[2] = 32'hFFFF_FFFE;  ts[2] = 1'b1;
        ta[3] = 32'hFFFF_FFFF;  tb[3] = 32'h10;         ts[3] = 1'b0;
        ta[4] = 32'hFFFF_FFFF;  tb[4] = 32'h10;         ts[4] = 1'b1;
        for (int i = 5; i < 11; i++) begin
            ta[i] = $urandom;
            tb[i] = $urandom >> $urandom_range(0, 28);
            if (tb[i] == 32'd0) tb[i] = 32'd9;
            ts[i] = i[0];
        end
        for (int i = 0; i < 11; i++) begin
            do_op(ta[i], tb[i], ts[i], got, lat, ok, gap);
            want = sbq.pop_front();
            total++; if (!ok) $display("FAIL arith[%0d] ready: got none want pulse", i); else passed++;
            total++; if (got.q !== want.q) $display("FAIL arith[%0d] quotient: got %h want %h", i, got.q, want.q); else passed++;
            total++; if (got.r !== want.r) $display("FAIL arith[%0d] remainder: got %h want %h", i, got.r, want.r); else passed++;
            total++; if (got.e !== want.e) $display("FAIL arith[%0d] exception: got %b want %b", i, got.e, want.e); else passed++;
            total++; if (lat !== 34) $display("FAIL arith[%0d] latency: got %0d want 34", i, lat); else passed++;
            total++; if (gap) $display("FAIL arith[%0d] busy: got low want high", i); else passed++;
        end
    endtask

    task automatic test_exceptions();
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic        ts [4];
        exp_t got;
        exp_t want;
        int   lat;
        bit   ok;
        bit   gap;
        ta[0] = 32'd5;          tb[0] = 32'd0;          ts[0] = 1'b1;
        ta[1] = 32'hFFFF_FFFF;  tb[1] = 32'd0;          ts[1] = 1'b0;
        ta[2] = 32'h8000_0000;  tb[2] = 32'hFFFF_FFFF;  ts[2] = 1'b1;
        ta[3] = 32'h8000_0000;  tb[3] = 32'hFFFF_FFFF;  ts[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], ts[i], got, lat, ok, gap);
            want = sbq.pop_front();
            total++; if (!ok) $display("FAIL exc[%0d] ready: got none want pulse", i); else passed++;
            total++; if (got.q !== want.q) $display("FAIL exc[%0d] quotient: got %h want %h", i, got.q, want.q); else passed++;
            total++; if (got.r !== want.r) $display("FAIL exc[%0d] remainder: got %h want %h", i, got.r, want.r); else passed++;
            total++; if (got.e !== want.e) $display("FAIL exc[%0d] exception: got %b want %b", i, got.e, want.e); else passed++;
            total++; if (lat !== (want.e ? 1 : 34)) $display("FAIL exc[%0d] latency: got %0d want %0d", i, lat, want.e ? 1 : 34); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t got;
        exp_t want;
        int   lat;
        bit   ok;
        bit   gap;
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        ta[0] = 32'd1000;  tb[0] = 32'd7;
        ta[1] = 32'd12345; tb[1] = 32'd0;
        ta[2] = 32'hFFFF_FF00; tb[2] = 32'd5;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], 1'b1, got, lat, ok, gap);
            want = sbq.pop_front();
            total++; if (!ok) $display("FAIL b2b[%0d] ready: got none want pulse", i); else passed++;
            total++; if ({got.q, got.r, got.e} !== {want.q, want.r, want.e})
                $display("FAIL b2b[%0d] result: got %h/%h/%b want %h/%h/%b", i, got.q, got.r, got.e, want.q, want.r, want.e);
            else passed++;
            total++; if (gap) $display("FAIL b2b[%0d] busy: got low want high", i); else passed++;
        end
        @(posedge clock);
        #1;
        total++; if ({rdy, bsy} !== 2'b00) $display("FAIL b2b idle after ready: got %b want 00", {rdy, bsy}); else passed++;
    endtask

    task automatic test_ignore_start();
        exp_t got;
        exp_t want;
        int   lat;
        bit   ok;
        bit   gap;
        int   extra;
        fork
            do_op(32'd100, 32'd7, 1'b0, got, lat, ok, gap);
            begin
                repeat (10) @(posedge clock);
                #2;
                opa   = 32'd999;
                opb   = 32'd1;
                start = 1'b1;
                @(posedge clock);
                #2;
                start = 1'b0;
            end
        join
        want = sbq.pop_front();
        total++; if ({got.q, got.r, got.e} !== {want.q, want.r, want.e})
            $display("FAIL ignore result: got %h/%h/%b want %h/%h/%b", got.q, got.r, got.e, want.q, want.r, want.e);
        else passed++;
        total++; if (lat !== 34) $display("FAIL ignore latency: got %0d want 34", lat); else passed++;
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (rdy) extra++;
        end
        total++; if (extra !== 0) $display("FAIL ignore extra ready: got %0d want 0", extra); else passed++;
    endtask

    task automatic test_reset_mid();
        exp_t got;
        exp_t want;
        int   lat;
        bit   ok;
        bit   gap;
        int   seen;
        opa   = 32'd1000;
        opb   = 32'd3;
        sm    = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        total++; if (quo !== 32'd0) $display("FAIL midreset quotient: got %h want 0", quo); else passed++;
        total++; if (rem !== 32'd0) $display("FAIL midreset remainder: got %h want 0", rem); else passed++;
        total++; if ({rdy, bsy, exc} !== 3'b000) $display("FAIL midreset ctrl: got %b want 000", {rdy, bsy, exc}); else passed++;
        @(posedge clock);
        #1;
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clock);
            #1;
            if (rdy || bsy) seen++;
        end
        total++; if (seen !== 0) $display("FAIL midreset activity: got %0d want 0", seen); else passed++;
        do_op(32'd1000, 32'd3, 1'b0, got, lat, ok, gap);
        want = sbq.pop_front();
        total++; if ({got.q, got.r, got.e} !== {want.q, want.r, want.e})
            $display("FAIL postreset result: got %h/%h/%b want %h/%h/%b", got.q, got.r, got.e, want.q, want.r, want.e);
        else passed++;
        total++; if (lat !== 34) $display("FAIL postreset latency: got %0d want 34", lat); else passed++;
    endtask

    task automatic test_width8();
        logic [7:0] ta [6];
        logic [7:0] tb [6];
        logic       ts [6];
        exp_t got;
        exp_t want;
        int   lat;
        bit   ok;
        bit   gap;
        ta[0] = 8'h80; tb[0] = 8'd3;  ts[0] = 1'b1;
        ta[1] = 8'h80; tb[1] = 8'hFF; ts[1] = 1'b1;
        ta[2] = 8'hFF; tb[2] = 8'd3;  ts[2] = 1'b0;
        ta[3] = 8'h7F; tb[3] = 8'hFE; ts[3] = 1'b1;
        ta[4] = 8'h05; tb[4] = 8'd0;  ts[4] = 1'b1;
        ta[5] = 8'hC8; tb[5] = 8'd7;  ts[5] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_op8(ta[i], tb[i], ts[i], got, lat, ok, gap);
            want = sbq.pop_front();
            total++; if (!ok) $display("FAIL w8[%0d] ready: got none want pulse", i); else passed++;
            total++; if ({got.q, got.r, got.e} !== {want.q, want.r, want.e})
                $display("FAIL w8[%0d] result: got %h/%h/%b want %h/%h/%b", i, got.q[7:0], got.r[7:0], got.e, want.q[7:0], want.r[7:0], want.e);
            else passed++;
            total++; if (lat !== (want.e ? 1 : 10)) $display("FAIL w8[%0d] latency: got %0d want %0d", i, lat, want.e ? 1 : 10); else passed++;
            total++; if (gap) $display("FAIL w8[%0d] busy: got low want high", i); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_exceptions();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_width8();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
